// File: rtl/cla_seq_adder_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cla_seq_pkg                                           |
// | Purpose  : Shared types and constants for the nibble-serial      |
// |            carry-lookahead adder sequencer.                      |
// | Contents : state_t (IDLE/RUN/DONE, 2 bits), NIBBLE_W             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cla_seq_adder_ctrl_if                                 |
// | Purpose  : Operand/result handshake bundle for the sequencer.    |
// | Ports    : in_valid/in_ready/a/b/cin   (operand channel)         |
// |            out_valid/out_ready/sum/cout/overflow (result channel)|
// |            master = producer/consumer side, slave = the adder    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_cla.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : CarryLookaheadAdder4bits                              |
// | Purpose  : 4-bit carry-lookahead adder, purely combinational.    |
// | Ports    : A, B (4b operands), Cin -> C (4b sum), Cout           |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module CarryLookaheadAdder4bits (
    input  wire logic [3:0] A,
    input  wire logic [3:0] B,
    input  wire logic       Cin,
    output logic      [3:0] C,
    output logic            Cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is a flat sum-of-products of g/p and Cin; no ripple.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign C    = w_p ^ w_c[3:0];
    assign Cout = w_c[4];
endmodule
`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cla_seq_adder_ctrl                                    |
// | Purpose  : WIDTH-bit adder built from one shared 4-bit CLA,      |
// |            one nibble per clock, LS nibble first.                |
// | Ports    : clk, rst_n (sync, active low)                         |
// |            bus (slave): in_valid/in_ready/a/b/cin,               |
// |                         out_valid/out_ready/sum/cout/overflow    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cla_seq_adder_ctrl_if.slave   bus
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [NIBBLE_W-1:0] w_cla_sum;
    logic                w_cla_cout;
    logic                w_last;
    logic                w_accept;

    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_accept = (r_state == IDLE) && bus.in_valid;

    CarryLookaheadAdder4bits u_cla (
        .A    (r_a[NIBBLE_W-1:0]),
        .B    (r_b[NIBBLE_W-1:0]),
        .Cin  (r_carry),
        .C    (w_cla_sum),
        .Cout (w_cla_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs come from the state register only, so there is
    // no combinational path from in_valid/out_ready to the bus.
    always_comb begin
        w_next_state = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_cla_sum;
            r_carry <= w_cla_cout;
            r_a     <= r_a >> NIBBLE_W;
            r_b     <= r_b >> NIBBLE_W;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_cla_cout;
                // On the last nibble bit 3 of the shift registers is the
                // original operand MSB, and bit 3 of the CLA sum is sum MSB.
                r_ovf  <= (r_a[NIBBLE_W-1] == r_b[NIBBLE_W-1]) &&
                          (w_cla_sum[NIBBLE_W-1] != r_a[NIBBLE_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Multi-cycle sequencer that performs WIDTH-bit additions using a single shared 4-bit carry-lookahead adder. It processes one nibble per clock, least-significant nibble first, and carries between nibbles through a registered carry. Operands arrive and results leave on valid/ready handshakes. The block sits between the ALU front end and the existing 4-bit CLA datapath, so wide adds are possible without replicating adder hardware.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands a/b/cin valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to nibble 0.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result a+b+cin mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  two's-complement overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: both 0.
  - DONE: out_valid=1, in_ready=0.
- IDLE→RUN on in_valid && in_ready.
  - a, b and cin are latched into shift registers and the carry register.
  - The nibble index is cleared to 0.
- RUN, each cycle:
  - The CLA input is the low nibble of the A and B shift registers plus the carry register.
  - At the edge, the CLA sum nibble is written to sum[4*idx+3:4*idx].
  - The carry register takes CLA Cout, both shift registers shift right by 4, and idx increments.
- RUN→DONE at the edge where idx==NIBBLES-1.
  - cout and overflow are registered at that same edge.
- DONE→IDLE on out_ready. sum, cout and overflow hold their values until the next acceptance.
- in_valid outside IDLE is ignored. Operands are not sampled and no state changes.
- The input changing while in RUN has no effect, because operands are latched.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is the signed interpretation only.
- rst_n low, in any state including mid-RUN: next state IDLE, the in-flight operation is discarded and no result is produced.
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, overflow=0, carry register=0, idx=0.

## Timing
- Acceptance edge E0 is the edge where in_valid && in_ready are both high.
- RUN occupies exactly NIBBLES cycles.
- out_valid is first high in the cycle following edge E_NIBBLES, i.e. latency is NIBBLES cycles from acceptance (4 cycles for WIDTH=16).
- The DONE→IDLE transition happens at the edge where out_valid && out_ready are both high.
- in_ready is high in the next cycle, so back-to-back throughput is one operation per NIBBLES+2 cycles with out_ready tied high.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from the state register only.
- The CLA sits in a single combinational stage per cycle: carry register → CLA → sum/carry registers.

## Structure
- Shared package cla_seq_pkg contains:
  - typedef enum {IDLE, RUN, DONE} for the state type, sized to 2 bits;
  - localparam NIBBLE_W = 4.
- One sub-module instance: the team's existing CarryLookaheadAdder4bits (A, B, Cin, C, Cout), instantiated once and used unmodified.
- Shift registers, nibble index ($clog2(NIBBLES) bits, minimum 1) and result registers live in the top module.

## Test plan
All scenarios use WIDTH=16.
- Reset: hold rst_n=0 for 2 cycles, then release → in_ready=1, out_valid=0, sum=0000, cout=0, overflow=0.
- a=0001, b=0004, cin=0 → sum=0005, cout=0, overflow=0, with out_valid first high exactly 4 cycles after acceptance.
- a=FFFF, b=FFFF, cin=1 → sum=FFFF, cout=1, overflow=0. Separately, a=7FFF, b=0001, cin=0 → sum=8000, cout=0, overflow=1, which checks carry propagation across all nibble boundaries.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → out_valid stays 1, sum stays stable and in_ready stays 0. A different operand pair presented with in_valid=1 during RUN or DONE is ignored. Raising out_ready returns the block to IDLE one edge later.
- Reset mid-operation: accept a=1234, b=1111, then drive rst_n=0 in the second RUN cycle → IDLE and out_valid never asserts. A following a=1234, b=1111 gives sum=2345.
- Back-to-back with out_ready tied 1: with a=0xC00C, b=0x0FF3, cin=0 followed by a=0xD, b=0x3, cin=1, expect sums 0xCFFF then 0x0011. The second operation is accepted exactly 6 cycles after the first.
